// File: rtl/mem_arbiter_pkg.sv
// mem_arbiter_pkg: shared encodings and constants for the byte-wide RAM arbiter
// Contents: request size codes, FSM state enum, IO address region, zero constants,
// and a helper mapping a size code to its byte count (11 behaves as word).
package mem_arbiter_pkg;
  typedef enum logic [1:0] {IDLE, READ, WRITE} state_t;
  localparam logic [1:0] SZ_BYTE = 2'b00;
  localparam logic [1:0] SZ_HALF = 2'b01;
  localparam logic [1:0] SZ_WORD = 2'b10;
  localparam logic [1:0] IO_REGION = 2'b11;
  localparam logic [7:0] ZERO8 = 8'h00;
  localparam logic [31:0] ZERO_WORD = 32'h0;
  function automatic logic [2:0] size_len(input logic [1:0] size);
    return size == SZ_BYTE ? 3'd1 : size == SZ_HALF ? 3'd2 : 3'd4;
  endfunction
endpackage

// File: rtl/mem_arbiter_if.sv
// mem_arbiter_if: pipeline and RAM-pin signal bundle for mem_arbiter
// slave  : arbiter side (takes fetch/data requests and RAM read byte, drives done/data/RAM pins)
// master : environment side (pipeline requesters plus RAM model)
interface mem_arbiter_if;
  logic        if_req_i;
  logic [31:0] if_addr_i;
  logic        if_flush_i;
  logic        if_done_o;
  logic [31:0] if_data_o;
  logic        dm_req_i;
  logic        dm_we_i;
  logic [1:0]  dm_size_i;
  logic [31:0] dm_addr_i;
  logic [31:0] dm_wdata_i;
  logic        dm_done_o;
  logic [31:0] dm_rdata_o;
  logic [7:0]  mem_din_i;
  logic [7:0]  mem_dout_o;
  logic [31:0] mem_a_o;
  logic        mem_wr_o;
  logic        io_buffer_full_i;
  modport slave (
    input  if_req_i, if_addr_i, if_flush_i, dm_req_i, dm_we_i, dm_size_i, dm_addr_i, dm_wdata_i,
           mem_din_i, io_buffer_full_i,
    output if_done_o, if_data_o, dm_done_o, dm_rdata_o, mem_dout_o, mem_a_o, mem_wr_o
  );
  modport master (
    output if_req_i, if_addr_i, if_flush_i, dm_req_i, dm_we_i, dm_size_i, dm_addr_i, dm_wdata_i,
           mem_din_i, io_buffer_full_i,
    input  if_done_o, if_data_o, dm_done_o, dm_rdata_o, mem_dout_o, mem_a_o, mem_wr_o
  );
endinterface

// File: rtl/mem_word_asm.sv
// mem_word_asm: byte-lane register file assembling little-endian read words
// Ports: clk, rst (sync, active-high); clr zeroes all lanes at transaction start;
// cap/cap_idx/din write one lane; word shows the lanes with the byte being captured
// this cycle already merged in, so the final byte can be registered on the same edge.
module mem_word_asm (
  input  logic        clk,
  input  logic        rst,
  input  logic        clr,
  input  logic        cap,
  input  logic [1:0]  cap_idx,
  input  logic [7:0]  din,
  output logic [31:0] word
);
  logic [3:0][7:0] lanes, merged;
  always_ff @(posedge clk)
    if (rst || clr) lanes <= '0;
    else if (cap) lanes[cap_idx] <= din;
  always_comb begin
    merged = lanes;
    if (cap) merged[cap_idx] = din;
  end
  assign word = merged;
endmodule

// File: rtl/mem_arbiter.sv
// mem_arbiter: serialises fetch and data requests onto a byte-wide RAM port
// Ports: clk; rst (sync, active-high); bus (mem_arbiter_if.slave) carrying the fetch port
// (if_*), the data port (dm_*), the RAM pins (mem_*) and io_buffer_full_i.
// Data requests beat fetches. Each 1/2/4-byte access takes one edge per byte plus a
// completion edge that pulses done. Option IO_FULL_STALL_EN: stores into the IO region
// (address bits 17:16 == 11) pause while io_buffer_full_i is high; otherwise it is ignored.
module mem_arbiter
  import mem_arbiter_pkg::*;
(
  input logic clk,
  input logic rst,
  mem_arbiter_if.slave bus
);
  state_t state, state_n;
  logic [2:0] idx, len, src_idx;
  logic [31:0] addr, wdata, src_addr, src_wdata, byte_addr, word;
  logic we, is_if, take_dm, take_if, busy, accept, abort, last, finish, want, stall, issue, src_we;
  always_ff @(posedge clk) state <= rst ? IDLE : state_n;
  always_comb state_n = accept ? (src_we ? WRITE : READ) : (abort || finish) ? IDLE : state;
  // In IDLE the first byte is issued from the incoming request on the accepting edge,
  // so the issue path selects between the live request and the latched one.
  always_comb begin
    take_dm = bus.dm_req_i && !bus.if_done_o && !bus.dm_done_o;
    take_if = bus.if_req_i && !bus.if_flush_i && !bus.dm_req_i && !bus.if_done_o && !bus.dm_done_o;
    busy = state != IDLE;
    accept = !busy && (take_dm || take_if);
    abort = state == READ && is_if && bus.if_flush_i;
    last = busy && idx == len;
    finish = last && !abort;
    src_we = busy ? we : take_dm && bus.dm_we_i;
    src_addr = busy ? addr : take_dm ? bus.dm_addr_i : bus.if_addr_i;
    src_wdata = busy ? wdata : bus.dm_wdata_i;
    src_idx = busy ? idx : 3'd0;
    byte_addr = src_addr + {29'd0, src_idx};
    want = accept || (busy && !last && !abort);
    issue = want && !stall;
  end
`ifdef IO_FULL_STALL_EN
  assign stall = want && src_we && byte_addr[17:16] == IO_REGION && bus.io_buffer_full_i;
`else
  logic unused_io;
  assign stall = 1'b0;
  assign unused_io = bus.io_buffer_full_i;
`endif
  always_ff @(posedge clk) begin
    if (rst) begin
      idx <= '0;
      len <= '0;
      addr <= ZERO_WORD;
      wdata <= ZERO_WORD;
      we <= 1'b0;
      is_if <= 1'b0;
      bus.mem_a_o <= ZERO_WORD;
      bus.mem_dout_o <= ZERO8;
      bus.mem_wr_o <= 1'b0;
      bus.if_done_o <= 1'b0;
      bus.dm_done_o <= 1'b0;
      bus.if_data_o <= ZERO_WORD;
      bus.dm_rdata_o <= ZERO_WORD;
    end else begin
      if (accept) begin
        addr <= src_addr;
        wdata <= src_wdata;
        we <= src_we;
        is_if <= !take_dm;
        len <= take_dm ? size_len(bus.dm_size_i) : 3'd4;
      end
      if (issue) begin
        bus.mem_a_o <= byte_addr;
        bus.mem_dout_o <= src_we ? src_wdata[{src_idx[1:0], 3'b000} +: 8] : ZERO8;
        bus.mem_wr_o <= src_we;
        idx <= src_idx + 3'd1;
      end else if (stall) begin
        bus.mem_wr_o <= 1'b0;
      end else if (finish || abort) begin
        bus.mem_a_o <= ZERO_WORD;
        bus.mem_dout_o <= ZERO8;
        bus.mem_wr_o <= 1'b0;
        idx <= '0;
      end
      bus.if_done_o <= finish && is_if;
      bus.dm_done_o <= finish && !is_if;
      if (finish && is_if) bus.if_data_o <= word;
      if (finish && !is_if && !we) bus.dm_rdata_o <= word;
    end
  end
  // Byte idx-1 arrives during the cycle after its address was driven.
  mem_word_asm u_asm (
    .clk(clk),
    .rst(rst),
    .clr(accept),
    .cap(state == READ),
    .cap_idx(idx[1:0] - 2'd1),
    .din(bus.mem_din_i),
    .word(word)
  );
endmodule

// File: tb/tb_mem_arbiter.sv
// tb_mem_arbiter: directed and randomized checks of mem_arbiter against a transaction model
module tb_mem_arbiter;
  import mem_arbiter_pkg::*;
  logic clk = 1'b0;
  logic rst;
  int n_cmp = 0;
  int n_err = 0;
  logic [7:0] ram [logic [31:0]];
  mem_arbiter_if bus();
  mem_arbiter u_dut (.clk(clk), .rst(rst), .bus(bus));
  always #5 clk = ~clk;

  // transaction model: current request, bytes issued so far, expected pins
  logic m_busy, m_if, m_we;
  int m_n, m_cnt;
  logic [31:0] m_base, m_wdata, m_word;
  logic [31:0] e_a, e_ifdata, e_dmdata;
  logic [7:0] e_dout;
  logic e_wr, e_ifd, e_dmd;

  function automatic logic [7:0] rd(input logic [31:0] a);
    return ram.exists(a) ? ram[a] : 8'(a ^ (a >> 8) ^ 32'h5A);
  endfunction

  function automatic int len_of(input logic [1:0] s);
    return s == SZ_BYTE ? 1 : s == SZ_HALF ? 2 : 4;
  endfunction

  function automatic logic stalled(input logic [31:0] a);
`ifdef IO_FULL_STALL_EN
    return a[17:16] == IO_REGION && bus.io_buffer_full_i;
`else
    return a[17:16] == IO_REGION && 1'b0;
`endif
  endfunction

  function automatic logic [31:0] pick_addr();
    case ($urandom_range(3))
      0: return $urandom;
      1: return 32'hFFFF_FFFC + 32'($urandom_range(3));
      2: return {14'd0, IO_REGION, 13'd0, 3'($urandom_range(7))};
      default: return 32'h100 + 32'($urandom_range(15));
    endcase
  endfunction

  task automatic model_issue();
    logic [31:0] a;
    a = m_base + 32'(m_cnt);
    if (m_we && stalled(a)) e_wr = 1'b0;
    else begin
      e_a = a;
      e_wr = m_we;
      if (m_we) e_dout = 8'(m_wdata >> (8 * m_cnt));
      m_cnt++;
    end
  endtask

  task automatic model_start(input logic is_if, input logic we, input int n, input logic [31:0] a, input logic [31:0] d);
    m_busy = 1'b1;
    m_if = is_if;
    m_we = we;
    m_n = n;
    m_base = a;
    m_wdata = d;
    m_cnt = 0;
    m_word = 32'h0;
    model_issue();
  endtask

  task automatic model_step();
    logic pend;
    if (rst) begin
      m_busy = 1'b0;
      e_a = 32'h0; e_dout = 8'h0; e_wr = 1'b0; e_ifd = 1'b0; e_dmd = 1'b0;
      e_ifdata = 32'h0; e_dmdata = 32'h0;
      return;
    end
    pend = e_ifd || e_dmd;
    e_ifd = 1'b0;
    e_dmd = 1'b0;
    if (!m_busy) begin
      if (!pend && bus.dm_req_i)
        model_start(1'b0, bus.dm_we_i, len_of(bus.dm_size_i), bus.dm_addr_i, bus.dm_wdata_i);
      else if (!pend && bus.if_req_i && !bus.if_flush_i)
        model_start(1'b1, 1'b0, 4, bus.if_addr_i, 32'h0);
    end else if (m_if && bus.if_flush_i) begin
      m_busy = 1'b0;
      e_a = 32'h0;
    end else begin
      if (!m_we) m_word = m_word | (32'(rd(m_base + 32'(m_cnt - 1))) << (8 * (m_cnt - 1)));
      if (m_cnt == m_n) begin
        m_busy = 1'b0;
        e_a = 32'h0;
        e_wr = 1'b0;
        if (m_if) begin
          e_ifd = 1'b1;
          e_ifdata = m_word;
        end else begin
          e_dmd = 1'b1;
          if (!m_we) e_dmdata = m_word;
        end
      end else model_issue();
    end
  endtask

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_cmp++;
    if (act !== exp) begin
      n_err++;
      $display("FAIL %s at %0t: got %h expected %h", name, $time, act, exp);
    end
  endtask

  task automatic compare();
    chk("mem_a", bus.mem_a_o, e_a);
    chk("mem_wr", 32'(bus.mem_wr_o), 32'(e_wr));
    if (e_wr) chk("mem_dout", 32'(bus.mem_dout_o), 32'(e_dout));
    chk("if_done", 32'(bus.if_done_o), 32'(e_ifd));
    chk("dm_done", 32'(bus.dm_done_o), 32'(e_dmd));
    chk("if_data", bus.if_data_o, e_ifdata);
    chk("dm_rdata", bus.dm_rdata_o, e_dmdata);
  endtask

  // one clock: model consumes current inputs, DUT takes the edge, outputs checked at negedge,
  // then the RAM commits any write and presents the byte for the address now on the pins
  task automatic tick();
    model_step();
    @(posedge clk);
    @(negedge clk);
    compare();
    if (bus.mem_wr_o) ram[bus.mem_a_o] = bus.mem_dout_o;
    bus.mem_din_i = rd(bus.mem_a_o);
  endtask

  task automatic dm_set(input logic we, input logic [1:0] sz, input logic [31:0] a, input logic [31:0] d);
    bus.dm_req_i = 1'b1;
    bus.dm_we_i = we;
    bus.dm_size_i = sz;
    bus.dm_addr_i = a;
    bus.dm_wdata_i = d;
  endtask

  task automatic quiet();
    bus.dm_req_i = 1'b0;
    bus.if_req_i = 1'b0;
    bus.if_flush_i = 1'b0;
    tick();
    tick();
  endtask

  task automatic wait_if(input string name);
    for (int k = 0; k < 12 && !bus.if_done_o; k++) tick();
    chk(name, 32'(bus.if_done_o), 32'd1);
  endtask

  task automatic wait_dm(input string name);
    for (int k = 0; k < 12 && !bus.dm_done_o; k++) tick();
    chk(name, 32'(bus.dm_done_o), 32'd1);
  endtask

  initial begin
    logic [7:0] sw_b [4];
    sw_b = '{8'hEF, 8'hBE, 8'hAD, 8'hDE};
    rst = 1'b1;
    bus.if_req_i = 1'b0; bus.if_addr_i = 32'h0; bus.if_flush_i = 1'b0;
    bus.dm_req_i = 1'b0; bus.dm_we_i = 1'b0; bus.dm_size_i = SZ_BYTE;
    bus.dm_addr_i = 32'h0; bus.dm_wdata_i = 32'h0;
    bus.mem_din_i = 8'h0; bus.io_buffer_full_i = 1'b0;
    ram[32'h1000] = 8'h13; ram[32'h1001] = 8'h05; ram[32'h1002] = 8'h00; ram[32'h1003] = 8'h00;
    ram[32'h20] = 8'h80;
    ram[32'h3000] = 8'h11; ram[32'h3001] = 8'h22; ram[32'h3002] = 8'h33; ram[32'h3003] = 8'h44;
    tick();
    tick();
    chk("rst_a", bus.mem_a_o, 32'h0);
    chk("rst_wr", 32'(bus.mem_wr_o), 32'd0);
    chk("rst_dout", 32'(bus.mem_dout_o), 32'd0);
    chk("rst_done", 32'({bus.if_done_o, bus.dm_done_o}), 32'd0);
    chk("rst_data", bus.if_data_o | bus.dm_rdata_o, 32'h0);
    rst = 1'b0;
    // word fetch at 0x1000
    bus.if_req_i = 1'b1;
    bus.if_addr_i = 32'h1000;
    for (int k = 0; k < 4; k++) begin
      tick();
      chk("fetch_addr", bus.mem_a_o, 32'h1000 + 32'(k));
      chk("fetch_early_done", 32'(bus.if_done_o), 32'd0);
    end
    tick();
    chk("fetch_done", 32'(bus.if_done_o), 32'd1);
    chk("fetch_data", bus.if_data_o, 32'h0000_0513);
    quiet();
    // data wins over a simultaneous fetch
    dm_set(1'b0, SZ_BYTE, 32'h20, 32'h0);
    bus.if_req_i = 1'b1;
    bus.if_addr_i = 32'h1000;
    tick();
    chk("prio_addr", bus.mem_a_o, 32'h20);
    tick();
    chk("lb_done", 32'(bus.dm_done_o), 32'd1);
    chk("lb_data", bus.dm_rdata_o, 32'h0000_0080);
    bus.dm_req_i = 1'b0;
    tick();
    chk("gap_addr", bus.mem_a_o, 32'h0);
    tick();
    chk("fetch_after_data", bus.mem_a_o, 32'h1000);
    wait_if("fetch2_done");
    chk("fetch2_data", bus.if_data_o, 32'h0000_0513);
    quiet();
    // store word then read it back
    dm_set(1'b1, SZ_WORD, 32'h100, 32'hDEAD_BEEF);
    for (int k = 0; k < 4; k++) begin
      tick();
      chk("sw_addr", bus.mem_a_o, 32'h100 + 32'(k));
      chk("sw_wr", 32'(bus.mem_wr_o), 32'd1);
      chk("sw_byte", 32'(bus.mem_dout_o), 32'(sw_b[k]));
    end
    tick();
    chk("sw_wr_drop", 32'(bus.mem_wr_o), 32'd0);
    chk("sw_done", 32'(bus.dm_done_o), 32'd1);
    chk("sw_addr_clr", bus.mem_a_o, 32'h0);
    quiet();
    dm_set(1'b0, SZ_WORD, 32'h100, 32'h0);
    wait_dm("lw_done");
    chk("lw_data", bus.dm_rdata_o, 32'hDEAD_BEEF);
    quiet();
    // flushed fetch, then a clean one
    bus.if_req_i = 1'b1;
    bus.if_addr_i = 32'h2000;
    tick();
    tick();
    chk("flush_pre_addr", bus.mem_a_o, 32'h2001);
    bus.if_flush_i = 1'b1;
    tick();
    chk("flush_addr", bus.mem_a_o, 32'h0);
    chk("flush_nodone", 32'(bus.if_done_o), 32'd0);
    bus.if_flush_i = 1'b0;
    bus.if_req_i = 1'b0;
    tick();
    chk("flush_nodone2", 32'(bus.if_done_o), 32'd0);
    bus.if_req_i = 1'b1;
    bus.if_addr_i = 32'h3000;
    wait_if("fetch3_done");
    chk("fetch3_data", bus.if_data_o, 32'h4433_2211);
    quiet();
    // halfword store wrapping the address space
    dm_set(1'b1, SZ_HALF, 32'hFFFF_FFFF, 32'h0000_1234);
    tick();
    chk("wrap_a0", bus.mem_a_o, 32'hFFFF_FFFF);
    chk("wrap_b0", 32'(bus.mem_dout_o), 32'h34);
    tick();
    chk("wrap_a1", bus.mem_a_o, 32'h0);
    chk("wrap_b1", 32'(bus.mem_dout_o), 32'h12);
    chk("wrap_wr1", 32'(bus.mem_wr_o), 32'd1);
    tick();
    chk("wrap_done", 32'(bus.dm_done_o), 32'd1);
    quiet();
    // reset in the middle of a store
    dm_set(1'b1, SZ_WORD, 32'h200, 32'h0102_0304);
    tick();
    tick();
    rst = 1'b1;
    tick();
    chk("rst_mid_wr", 32'(bus.mem_wr_o), 32'd0);
    chk("rst_mid_done", 32'(bus.dm_done_o), 32'd0);
    rst = 1'b0;
    quiet();
`ifdef IO_FULL_STALL_EN
    dm_set(1'b1, SZ_BYTE, 32'h3_0000, 32'h77);
    bus.io_buffer_full_i = 1'b1;
    for (int k = 0; k < 3; k++) begin
      tick();
      chk("io_stall_wr", 32'(bus.mem_wr_o), 32'd0);
      chk("io_stall_done", 32'(bus.dm_done_o), 32'd0);
    end
    bus.io_buffer_full_i = 1'b0;
    tick();
    chk("io_wr", 32'(bus.mem_wr_o), 32'd1);
    chk("io_addr", bus.mem_a_o, 32'h3_0000);
    chk("io_byte", 32'(bus.mem_dout_o), 32'h77);
    tick();
    chk("io_done", 32'(bus.dm_done_o), 32'd1);
    quiet();
`endif
    for (int c = 0; c < 4000; c++) begin
      rst = $urandom_range(599) == 0;
      if (bus.dm_done_o) bus.dm_req_i = 1'b0;
      if (!bus.dm_req_i && $urandom_range(3) == 0)
        dm_set(1'($urandom_range(1)), 2'($urandom_range(3)), pick_addr(), $urandom);
      if (bus.if_done_o) bus.if_req_i = 1'b0;
      bus.if_flush_i = bus.if_req_i && $urandom_range(11) == 0;
      if (bus.if_flush_i && $urandom_range(1) == 0) bus.if_req_i = 1'b0;
      if (!bus.if_req_i && $urandom_range(2) == 0) begin
        bus.if_req_i = 1'b1;
        bus.if_addr_i = pick_addr();
      end
      bus.io_buffer_full_i = $urandom_range(2) == 0;
      tick();
    end
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
    $finish;
  end
endmodule

// File: doc/mem_arbiter.md
# mem_arbiter

Single owner of the byte-wide external RAM port, shared between instruction fetch (icache miss refill) and the MEM stage (loads/stores). It serialises each 1/2/4-byte request into byte cycles, assembles little-endian read data, and returns a one-cycle done pulse. Data requests have fixed priority over instruction requests. It sits between the pipeline and the RAM pins in the CPU top.

## Interface
Parameters:
- none; encodings come from the shared defines.

Ports:
- clk  in  1  system clock, rising edge
- rst  in  1  reset; synchronous, active-high
- if_req_i  in  1  instruction word read request; held until if_done_o or flush
- if_addr_i  in  32  fetch byte address
- if_flush_i  in  1  abort pending/in-flight fetch
- if_done_o  out  1  one-cycle pulse, if_data_o valid
- if_data_o  out  32  fetched word, little-endian
- dm_req_i  in  1  data request; held until dm_done_o
- dm_we_i  in  1  1 = store, 0 = load
- dm_size_i  in  2  00 byte, 01 half, 10 word (11 treated as word)
- dm_addr_i  in  32  data byte address
- dm_wdata_i  in  32  store data, low bytes used
- dm_done_o  out  1  one-cycle completion pulse
- dm_rdata_o  out  32  load data, zero-extended raw bytes
- mem_din_i  in  8  RAM read byte
- mem_dout_o  out  8  RAM write byte
- mem_a_o  out  32  RAM byte address
- mem_wr_o  out  1  RAM write enable
- io_buffer_full_i  in  1  UART output buffer full

## Operation
- States: IDLE, READ, WRITE. Byte index idx (3 bits), length N = 1/2/4 from size; instruction port always N=4, load.
- IDLE accepts only when done pulses are low. dm_req_i wins over if_req_i when both are high. The winner's addr/size/we/wdata are latched.
- READ: edge E0 drives mem_a_o=addr. Each edge Ek (1≤k<N) captures mem_din_i into byte k-1 and drives addr+k. Edge EN captures byte N-1, pulses done, mem_a_o=0, returns to IDLE.
- WRITE: edge Ek (0≤k<N) drives addr+k, byte k of wdata, mem_wr_o=1. Edge EN drives mem_wr_o=0, mem_a_o=0, pulses done, returns to IDLE.
- Address increment is 32-bit modular: 0xFFFFFFFF+1 = 0.
- Unused upper bytes of dm_rdata_o are 0. Sign extension is the requester's job.
- if_flush_i high in IDLE blocks if_req_i acceptance. High during an instruction READ returns the block to IDLE at the next edge, with mem_a_o=0 and no if_done_o. Flush never affects data transactions.
- Data outputs hold their last value until the next completion.

## Timing
- Reset: state IDLE, idx 0, all outputs 0 (mem_wr_o=0, mem_a_o=0, mem_dout_o=0, both done 0, both data 0).
- RAM read latency is 1 cycle: mem_din_i in cycle after edge Ek corresponds to mem_a_o set at Ek.
- Latency from accepting edge to done pulse is N edges, for both read and write. Word fetch: done 4 edges after accept.
- Back-to-back: the next accept is no earlier than the edge after the done pulse, giving one idle cycle between transactions.
- Reset mid-transaction aborts immediately: no done, mem_wr_o=0 at the reset edge.
- An instruction request that loses arbitration waits with no timeout.

## Configuration
- IO_FULL_STALL_EN defined: in WRITE, if addr[17:16]==2'b11 and io_buffer_full_i=1, the current byte is not issued. mem_wr_o is held 0, idx and address are frozen, and the write resumes on the first edge with io_buffer_full_i=0. Done latency grows by the stalled cycles.
- Undefined: io_buffer_full_i is ignored; IO stores run at full rate.

## Structure
- Shared defines: size encodings, state encodings, IO address-region constant, Zero8/ZeroWord.
- One natural sub-module: mem_word_asm. It holds the byte-lane register file, takes a capture index and byte, presents the assembled 32-bit word, and clears upper lanes at transaction start.

## Test plan
- Word fetch at 0x1000 with RAM bytes 0x13,0x05,0x00,0x00 -> mem_a_o 0x1000..0x1003 on consecutive cycles; if_done_o 4 edges after accept; if_data_o=0x00000513.
- Simultaneous dm_req (LB at 0x20 holding 0x80) and if_req -> data served first, dm_rdata_o=0x00000080 after 1 edge; the fetch starts the edge after the done pulse.
- SW 0xDEADBEEF at 0x100 -> 4 write cycles with bytes EF,BE,AD,DE at 0x100..0x103; mem_wr_o drops and dm_done_o pulses at edge 4.
- Fetch at 0x2000 with if_flush_i pulsed at idx=2 -> IDLE next edge; no if_done_o; a new fetch at 0x3000 completes normally.
- SH at 0xFFFFFFFF -> bytes issued to 0xFFFFFFFF then 0x00000000.
- With IO_FULL_STALL_EN: SB to 0x30000 with io_buffer_full_i high for 3 cycles -> mem_wr_o=0 for those cycles; byte written on release; done delayed by 3.
